// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : store_monitor
// Brief    : Observes data-memory stores, buffers them in a FIFO for draining,
//            counts cycles/stores and decides pass/fail/timeout from a
//            signature store.
// Revision : 1.0 - initial release
// ============================================================================
module store_monitor #(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] PASS_ADR  = 32'd100,
  parameter logic [31:0] PASS_DATA = 32'd25,
  parameter logic [15:0] TIMEOUT   = 16'd200
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [31:0]                rd_adr,
  output logic [31:0]                rd_data,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic                       overflow,
  output logic [15:0]                store_count,
  output logic [15:0]                cycle_count,
  output logic                       done,
  output logic                       pass,
  output logic                       fail,
  output logic                       timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [15:0]   TIMEOUT_L = TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  state_t          state;
  logic [63:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic            capture;
  logic            pop_ok;
  logic            push_ok;
  logic            sig_hit;
  logic [LW-1:0]   next_level;

  // Capture/pop qualification; a full FIFO still accepts a store when an
  // entry leaves on the same edge. An empty FIFO never pops, so a store
  // landing in it cannot be read back on the same edge.
  always_comb begin
    capture    = (state == ST_RUN) && MemWrite;
    pop_ok     = rd_en && !fifo_empty;
    push_ok    = capture && (!fifo_full || pop_ok);
    sig_hit    = capture && (DataAdr == PASS_ADR);
    next_level = fifo_level + LW'(push_ok) - LW'(pop_ok);
  end

  // Storage array; contents need no reset because occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {DataAdr, WriteData};
    end
  end

  // FIFO pointers, occupancy flags, read port and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_adr     <= '0;
      rd_data    <= '0;
    end else begin
      rd_valid <= pop_ok;
      if (pop_ok) begin
        rd_adr  <= mem[rd_ptr][63:32];
        rd_data <= mem[rd_ptr][31:0];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (capture && !push_ok) begin
        overflow <= 1'b1;
      end
      fifo_level <= next_level;
      fifo_full  <= (next_level == DEPTH_L);
      fifo_empty <= (next_level == '0);
    end
  end

  // Run-control FSM with registered status outputs and RUN-only counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      store_count <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          cycle_count <= cycle_count + 16'd1;
          if (capture && (store_count != 16'hFFFF)) begin
            store_count <= store_count + 16'd1;
          end
          // A signature store outranks a timeout landing on the same edge.
          if (sig_hit) begin
            done <= 1'b1;
            if (WriteData == PASS_DATA) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state <= ST_FAIL;
              fail  <= 1'b1;
            end
          end else if (cycle_count == TIMEOUT_L) begin
            state   <= ST_TIMEOUT;
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_monitor
// Brief    : Directed self-checking bench for store_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_adr;
  logic [31:0] rd_data;
  logic [3:0]  fifo_level;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic [15:0] store_count;
  logic [15:0] cycle_count;
  logic        done;
  logic        pass;
  logic        fail;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  store_monitor #(
    .DEPTH(8), .PASS_ADR(32'd100), .PASS_DATA(32'd25), .TIMEOUT(16'd200)
  ) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData), .rd_en(rd_en), .rd_valid(rd_valid),
    .rd_adr(rd_adr), .rd_data(rd_data), .fifo_level(fifo_level),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .store_count(store_count), .cycle_count(cycle_count), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] a, input logic [31:0] d);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_adr"}, rd_adr, a);
    check({tag, "_data"}, rd_data, d);
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    check("rst_level", 32'(fifo_level), 0);
    check("rst_empty", 32'(fifo_empty), 1);
    check("rst_full", 32'(fifo_full), 0);
    check("rst_flags", {28'd0, done, pass, fail, timeout}, 0);
    check("rst_cnt", {store_count, cycle_count}, 0);
    check("rst_rd", {31'd0, rd_valid} | rd_adr | rd_data, 0);

    // ---------------- pass path: stores on edges 3, 5, 10 ----------------
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      if (e == 3)       store(4, 7);
      else if (e == 5)  store(8, 9);
      else if (e == 10) store(100, 25);
      else              tick();
    end
    check("pass_pass", 32'(pass), 1);
    check("pass_done", 32'(done), 1);
    check("pass_fail", 32'(fail), 0);
    check("pass_stores", 32'(store_count), 3);
    check("pass_level", 32'(fifo_level), 3);
    check("pass_cycles", 32'(cycle_count), 10);
    pop_expect("drain0", 4, 7);
    pop_expect("drain1", 8, 9);
    pop_expect("drain2", 100, 25);
    check("drain_empty", 32'(fifo_empty), 1);
    tick();
    check("drain_novalid", 32'(rd_valid), 0);

    // ---------------- fail path and freeze ----------------
    do_reset();
    store(100, 24);
    check("fail_fail", 32'(fail), 1);
    check("fail_timeout", 32'(timeout), 0);
    check("fail_pass", 32'(pass), 0);
    store(0, 1);
    check("freeze_stores", 32'(store_count), 1);
    check("freeze_level", 32'(fifo_level), 1);
    check("freeze_cycles", 32'(cycle_count), 1);

    // ---------------- timeout ----------------
    do_reset();
    repeat (199) tick();
    check("to_before", 32'(timeout), 0);
    check("to_cyc199", 32'(cycle_count), 199);
    tick();
    check("to_timeout", 32'(timeout), 1);
    check("to_fail", 32'(fail), 1);
    check("to_done", 32'(done), 1);
    check("to_cyc200", 32'(cycle_count), 200);
    tick();
    check("to_frozen", 32'(cycle_count), 200);

    // ---------------- signature wins on the timeout edge ----------------
    do_reset();
    repeat (199) tick();
    store(100, 25);
    check("prec_pass", 32'(pass), 1);
    check("prec_timeout", 32'(timeout), 0);
    check("prec_stores", 32'(store_count), 1);

    // ---------------- overflow ----------------
    do_reset();
    for (int i = 1; i <= 10; i++) store(i, 1000 + i);
    check("ovf_full", 32'(fifo_full), 1);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_stores", 32'(store_count), 10);
    check("ovf_level", 32'(fifo_level), 8);
    // push + pop on a full FIFO
    rd_en = 1'b1; MemWrite = 1'b1; DataAdr = 50; WriteData = 50;
    tick();
    rd_en = 1'b0; MemWrite = 1'b0;
    check("pp_level", 32'(fifo_level), 8);
    check("pp_valid", 32'(rd_valid), 1);
    check("pp_adr", rd_adr, 1);
    check("pp_data", rd_data, 1001);
    check("pp_ovf", 32'(overflow), 1);
    for (int i = 2; i <= 8; i++) pop_expect("ovf_drain", i, 1000 + i);
    pop_expect("ovf_last", 50, 50);
    check("ovf_empty", 32'(fifo_empty), 1);

    // ---------------- empty corner ----------------
    do_reset();
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("emp_novalid", 32'(rd_valid), 0);
    check("emp_hold", rd_adr, 0);
    rd_en = 1'b1; MemWrite = 1'b1; DataAdr = 7; WriteData = 8;
    tick();
    rd_en = 1'b0; MemWrite = 1'b0;
    check("emp_push_novalid", 32'(rd_valid), 0);
    check("emp_push_level", 32'(fifo_level), 1);
    pop_expect("emp_pop", 7, 8);
    check("emp_pop_level", 32'(fifo_level), 0);

    // ---------------- reset mid-run ----------------
    do_reset();
    for (int i = 1; i <= 5; i++) store(i, i);
    repeat (35) tick();
    check("mid_level", 32'(fifo_level), 5);
    check("mid_cycles", 32'(cycle_count), 40);
    reset = 1'b1; rd_en = 1'b1; MemWrite = 1'b1; DataAdr = 100; WriteData = 24;
    tick();
    reset = 1'b0; rd_en = 1'b0; MemWrite = 1'b0;
    check("mid_level0", 32'(fifo_level), 0);
    check("mid_empty", 32'(fifo_empty), 1);
    check("mid_cnt", {store_count, cycle_count}, 0);
    check("mid_state", {28'd0, done, pass, fail, timeout}, 0);
    check("mid_ovf_valid", {30'd0, overflow, rd_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_monitor.md
# store_monitor

Synchronous observer on the processor's data-memory write port, downstream of `top` (consumes `MemWrite`, `DataAdr`, `WriteData`). It counts cycles and stores and buffers every captured store in a small FIFO for later draining by a bench or debug port. It also runs a run-control FSM that decides pass/fail/timeout from a signature store, replacing ad-hoc cycle-count checks in benches.

## Interface
- `DEPTH`, 8: FIFO entries, power of two, ≥2
- `PASS_ADR`, 32'd100: signature store address
- `PASS_DATA`, 32'd25: signature store data meaning pass
- `TIMEOUT`, 16'd200: cycles in RUN before forced timeout, ≥1
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `MemWrite` in 1: store strobe from `top`
- `DataAdr` in 32: store address
- `WriteData` in 32: store data
- `rd_en` in 1: FIFO pop request
- `rd_valid` out 1: `rd_adr`/`rd_data` valid this cycle
- `rd_adr` out 32: popped store address
- `rd_data` out 32: popped store data
- `fifo_level` out $clog2(DEPTH)+1: current occupancy
- `fifo_full` out 1: level == DEPTH
- `fifo_empty` out 1: level == 0
- `overflow` out 1: sticky, a store was dropped
- `store_count` out 16: stores seen in RUN, saturates at 16'hFFFF
- `cycle_count` out 16: cycles spent in RUN
- `done` out 1: state != RUN
- `pass` out 1: state == PASS
- `fail` out 1: state == FAIL or TIMEOUT
- `timeout` out 1: state == TIMEOUT

## Operation
- FSM states: RUN, PASS, FAIL, TIMEOUT. RUN is the reset state. PASS, FAIL and TIMEOUT are terminal; only `reset` leaves them.
- Capture: on an edge in RUN with `MemWrite`=1:
  - `store_count` increments (saturating).
  - {`DataAdr`,`WriteData`} is pushed when not full, or when full with a successful pop on the same edge.
  - Otherwise the store is dropped and `overflow` is set (sticky until reset).
- Signature: in RUN with `MemWrite`=1 and `DataAdr`==`PASS_ADR`:
  - `WriteData`==`PASS_DATA` → PASS.
  - Any other data → FAIL.
  - The signature store itself is also captured and counted.
- Timeout: `cycle_count` increments every edge in RUN. When `cycle_count`==`TIMEOUT`-1 on an edge, the next state is TIMEOUT.
  - A signature store on that same edge takes precedence: the next state is PASS/FAIL, not TIMEOUT.
- Terminal states: no capture. `store_count` and `cycle_count` frozen. `MemWrite` ignored. The FIFO remains poppable.
- Pop: `rd_en`=1 with FIFO non-empty at the edge → the oldest entry is registered to `rd_adr`/`rd_data` and `rd_valid`=1 for that one following cycle.
  - `rd_en` on an empty FIFO is ignored: `rd_valid`=0 and data holds its previous value.
  - A push into an empty FIFO is not poppable on the same edge.
- Simultaneous push and pop on the same edge: level unchanged (non-empty case). Pointers wrap modulo DEPTH.

## Timing
- Reset (edge with `reset`=1) puts every output at 0, except `fifo_empty`=1. State = RUN, pointers = 0, `overflow` cleared.
- Reset mid-operation discards FIFO contents and counters on that edge, with no partial pop. A `rd_en` or `MemWrite` during reset is ignored.
- Store → `fifo_level` increments: 1 cycle (visible after the capturing edge).
- Signature store → `done`/`pass`/`fail`: 1 cycle.
- `rd_en` → `rd_valid`: 1 cycle, no backpressure. Back-to-back `rd_en` drains one entry per cycle.
- Status flags `fifo_full`, `fifo_empty` and `fifo_level` are registered state and update on the same edge as the pointers.
- With no signature store, `timeout` rises after exactly `TIMEOUT` edges in RUN, with `cycle_count`==`TIMEOUT` frozen.

## Test plan
- Pass path:
  - Stimulus: after reset, stores (4,7), (8,9), then (100,25) on cycles 3, 5, 10.
  - Required: `pass`=1 at cycle 11, `store_count`=3, `fifo_level`=3.
  - Draining with 3× `rd_en` returns (4,7), (8,9), (100,25) in order, then `fifo_empty`=1.
- Fail path and freeze:
  - Stimulus: store (100,24), then a further store (0,1).
  - Required: `fail`=1, `timeout`=0. The extra store is not captured and `store_count`=1.
- Timeout and precedence:
  - With `TIMEOUT`=200, no stores → `timeout`=1 and `fail`=1 after 200 edges, `cycle_count`=200.
  - Rerun with (100,25) on the 200th edge → `pass`=1, `timeout`=0.
- Overflow:
  - With `DEPTH`=8, issue 10 consecutive stores without popping.
  - Required: `fifo_full`=1, `overflow`=1, `store_count`=10. Drain returns the first 8 stores only.
  - With full FIFO, push+pop on the same edge → level stays 8, `overflow` unchanged.
- Empty corner: `rd_en` on an empty FIFO → `rd_valid`=0. `rd_en` together with the first push → `rd_valid`=0, `fifo_level`=1.
- Reset mid-run: assert `reset` with level 5 and `cycle_count` 40 → next cycle all counters 0, `fifo_empty`=1, state RUN, `overflow`=0.
